// File: rtl/kbd_pkg.sv
// Shared keyboard constants: command codes and PS/2 set-2 scan codes.
// Used by the command queue and by any block that decodes arrow keys.
package kbd_pkg;

  localparam logic [2:0] CMD_NONE  = 3'd0;
  localparam logic [2:0] CMD_UP    = 3'd1;
  localparam logic [2:0] CMD_RIGHT = 3'd2;
  localparam logic [2:0] CMD_DOWN  = 3'd3;
  localparam logic [2:0] CMD_LEFT  = 3'd4;

  localparam logic [7:0] SC_UP     = 8'h75;
  localparam logic [7:0] SC_DOWN   = 8'h72;
  localparam logic [7:0] SC_RIGHT  = 8'h74;
  localparam logic [7:0] SC_LEFT   = 8'h6B;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/keyboard_cmd_queue_if.sv
// Bundle between PS/2 driver, command queue and consumer.
// slave: queue side (events in, commands out); master: driver/consumer side.
interface keyboard_cmd_queue_if #(
  parameter int CMD_W = 3,
  parameter int DEPTH = 4
);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic             valid;
  logic             makeBreak;
  logic [7:0]       outCode;
  logic [CMD_W-1:0] cmd;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [LVL_W-1:0] level;
  logic             overflow;

  modport master (
    output valid, makeBreak, outCode, cmd_ready,
    input  cmd, cmd_valid, level, overflow
  );

  modport slave (
    input  valid, makeBreak, outCode, cmd_ready,
    output cmd, cmd_valid, level, overflow
  );
endinterface

// File: rtl/keyboard_cmd_queue_fifo.sv
// cmd_fifo: show-ahead registered FIFO with occupancy counter and drop pulse.
// Ports: i_push/i_data in, i_pop out-ack, o_data/o_valid head, o_level, o_overflow.
module cmd_fifo #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_valid,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [LW-1:0]    r_level;
  logic             r_ovf;

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push;

  assign w_empty = (r_level == '0);
  assign w_full  = (r_level == LW'(DEPTH));
  assign w_pop   = i_pop && !w_empty;
  // a pop frees the slot in the same cycle, so full+pop still accepts
  assign w_push  = i_push && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= i_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_level <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop)  r_rd <= r_rd + AW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
      r_ovf <= i_push && w_full && !w_pop;
    end
  end

  assign o_data     = w_empty ? '0 : r_mem[r_rd];
  assign o_valid    = !w_empty;
  assign o_level    = r_level;
  assign o_overflow = r_ovf;
endmodule

// File: rtl/keyboard_cmd_queue.sv
// Scan-code to command mapper with typematic repeat, buffered in cmd_fifo.
// Ports: clk, reset (sync, active-high), bus (keyboard_cmd_queue_if.slave).
module keyboard_cmd_queue
  import kbd_pkg::*;
#(
  parameter int                    NUM_KEYS     = 4,
  parameter int                    CMD_W        = 3,
  parameter logic [NUM_KEYS*8-1:0] KEY_CODES    =
    {SC_LEFT, SC_RIGHT, SC_DOWN, SC_UP},
  parameter logic [NUM_KEYS*CMD_W-1:0] KEY_CMDS =
    {3'd4, 3'd2, 3'd3, 3'd1},
  parameter int                    DEPTH        = 4,
  parameter bit                    REPEAT_EN    = 1'b1,
  parameter int                    REPEAT_DELAY = 25_000_000,
  parameter int                    REPEAT_RATE  = 5_000_000
) (
  input  logic clk,
  input  logic reset,
  keyboard_cmd_queue_if.slave bus
);
  localparam int MAXR  = max2(REPEAT_DELAY, REPEAT_RATE);
  localparam int CNT_W = $clog2(MAXR + 1);
  localparam int IDX_W = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;

  logic [IDX_W-1:0] r_held;
  logic             r_held_v;
  logic [CNT_W-1:0] r_cnt;

  logic             w_hit;
  logic [IDX_W-1:0] w_idx;
  logic             w_make;
  logic             w_rel;
  logic             w_exp;
  logic             w_push;
  logic [CMD_W-1:0] w_cmd;

  // scan downward so the lowest matching index is the one kept
  always_comb begin
    w_hit = 1'b0;
    w_idx = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (bus.outCode == KEY_CODES[i*8 +: 8]) begin
        w_hit = 1'b1;
        w_idx = IDX_W'(i);
      end
    end
  end

  assign w_make = bus.valid && bus.makeBreak && w_hit;
  assign w_rel  = bus.valid && !bus.makeBreak && w_hit &&
                  r_held_v && (w_idx == r_held);
  assign w_exp  = REPEAT_EN && r_held_v && (r_cnt == CNT_W'(1));
  // a make absorbs a coinciding expiry; a release cancels it
  assign w_push = w_make || (w_exp && !w_rel);
  assign w_cmd  = w_make ? KEY_CMDS[w_idx*CMD_W +: CMD_W]
                         : KEY_CMDS[r_held*CMD_W +: CMD_W];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_held   <= '0;
      r_held_v <= 1'b0;
      r_cnt    <= '0;
    end else if (w_make) begin
      r_held   <= w_idx;
      r_held_v <= 1'b1;
      r_cnt    <= CNT_W'(REPEAT_DELAY);
    end else if (w_rel) begin
      r_held_v <= 1'b0;
      r_cnt    <= '0;
    end else if (REPEAT_EN && r_held_v) begin
      r_cnt <= w_exp ? CNT_W'(REPEAT_RATE) : r_cnt - CNT_W'(1);
    end
  end

  cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .i_push     (w_push),
    .i_data     (w_cmd),
    .i_pop      (bus.cmd_ready),
    .o_data     (bus.cmd),
    .o_valid    (bus.cmd_valid),
    .o_level    (bus.level),
    .o_overflow (bus.overflow)
  );
endmodule

// File: tb/tb_keyboard_cmd_queue.sv
// Bench for keyboard_cmd_queue: directed scenarios plus random traffic
// against a time-stamped queue model.
module tb_keyboard_cmd_queue;
  localparam int D   = 10;
  localparam int R   = 4;
  localparam int DEP = 4;
  localparam int CW  = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  keyboard_cmd_queue_if #(.CMD_W(CW), .DEPTH(DEP)) bus ();

  keyboard_cmd_queue #(
    .DEPTH        (DEP),
    .REPEAT_DELAY (D),
    .REPEAT_RATE  (R)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_cmp = 0;
  int n_err = 0;
  int t = 0;

  int codes [4] = '{8'h75, 8'h72, 8'h74, 8'h6B};
  int cmds  [4] = '{1, 3, 2, 4};

  int q [$];
  bit m_hv = 0;
  int m_held = 0;
  int m_next = 0;
  bit m_ovf = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s t=%0d got=%0h want=%0h", tag, t, obs, exp);
    end
  endtask

  function automatic int lookup(input logic [7:0] c);
    for (int i = 0; i < 4; i++)
      if (int'(c) == codes[i]) return i;
    return -1;
  endfunction

  task automatic model(input logic v, input logic mb,
                       input logic [7:0] c, input logic rdy,
                       input logic rst);
    int idx;
    bit push;
    int pv;
    if (rst) begin
      q.delete();
      m_hv = 0;
      m_ovf = 0;
      return;
    end
    idx = lookup(c);
    push = 0;
    pv = 0;
    m_ovf = 0;
    if (v && mb && idx >= 0) begin
      push = 1;
      pv = cmds[idx];
      m_held = idx;
      m_hv = 1;
      m_next = t + D;
    end else if (v && !mb && idx >= 0 && m_hv && idx == m_held) begin
      m_hv = 0;
    end else if (m_hv && t == m_next) begin
      push = 1;
      pv = cmds[m_held];
      m_next = t + R;
    end
    if (rdy && q.size() > 0) void'(q.pop_front());
    if (push) begin
      if (q.size() < DEP) q.push_back(pv);
      else m_ovf = 1;
    end
  endtask

  task automatic cyc(input logic v, input logic mb,
                     input logic [7:0] c, input logic rdy,
                     input logic rst);
    int ec;
    bus.valid = v;
    bus.makeBreak = mb;
    bus.outCode = c;
    bus.cmd_ready = rdy;
    reset = rst;
    @(posedge clk);
    model(v, mb, c, rdy, rst);
    t++;
    #1;
    ec = (q.size() > 0) ? q[0] : 0;
    chk("cmd", 32'(bus.cmd), 32'(ec));
    chk("cmd_valid", 32'(bus.cmd_valid), 32'(q.size() > 0));
    chk("level", 32'(bus.level), 32'(q.size()));
    chk("overflow", 32'(bus.overflow), 32'(m_ovf));
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) cyc(0, 0, 8'h00, rdy, 0);
  endtask

  task automatic rst_seq();
    cyc(0, 0, 8'h00, 0, 1);
    cyc(0, 0, 8'h00, 0, 1);
  endtask

  initial begin
    bus.valid = 0;
    bus.makeBreak = 0;
    bus.outCode = 0;
    bus.cmd_ready = 0;
    rst_seq();
    chk("reset_level", 32'(bus.level), 32'd0);

    // single press
    idle(5, 1);
    cyc(1, 1, 8'h75, 1, 0);
    chk("single_cmd", 32'(bus.cmd), 32'd1);
    idle(1, 1);
    cyc(1, 0, 8'h75, 1, 0);
    idle(15, 1);

    // auto-repeat of left key
    rst_seq();
    cyc(1, 1, 8'h6B, 1, 0);
    idle(24, 1);
    cyc(1, 0, 8'h6B, 1, 0);
    idle(12, 1);

    // overflow with consumer stalled
    rst_seq();
    cyc(1, 1, 8'h74, 0, 0); cyc(1, 0, 8'h74, 0, 0);
    cyc(1, 1, 8'h72, 0, 0); cyc(1, 0, 8'h72, 0, 0);
    cyc(1, 1, 8'h75, 0, 0); cyc(1, 0, 8'h75, 0, 0);
    cyc(1, 1, 8'h6B, 0, 0); cyc(1, 0, 8'h6B, 0, 0);
    cyc(1, 1, 8'h74, 0, 0);
    chk("ovf_pulse", 32'(bus.overflow), 32'd1);
    cyc(1, 0, 8'h74, 0, 0);
    chk("ovf_level", 32'(bus.level), 32'd4);
    chk("ovf_head", 32'(bus.cmd), 32'd2);
    idle(6, 1);

    // full FIFO with simultaneous push and pop
    rst_seq();
    cyc(1, 1, 8'h74, 0, 0); cyc(1, 0, 8'h74, 0, 0);
    cyc(1, 1, 8'h72, 0, 0); cyc(1, 0, 8'h72, 0, 0);
    cyc(1, 1, 8'h75, 0, 0); cyc(1, 0, 8'h75, 0, 0);
    cyc(1, 1, 8'h6B, 0, 0); cyc(1, 0, 8'h6B, 0, 0);
    cyc(1, 1, 8'h72, 1, 0);
    chk("fullpp_level", 32'(bus.level), 32'd4);
    cyc(1, 0, 8'h72, 0, 0);
    idle(6, 1);

    // make collides with repeat expiry; unmatched; foreign break
    rst_seq();
    cyc(1, 1, 8'h75, 1, 0);
    idle(9, 1);
    cyc(1, 1, 8'h72, 1, 0);
    idle(12, 1);
    cyc(1, 1, 8'h1C, 1, 0);
    cyc(1, 0, 8'h75, 1, 0);
    idle(10, 1);
    cyc(1, 0, 8'h72, 1, 0);
    idle(8, 1);

    // reset in the middle of a hold
    rst_seq();
    cyc(1, 1, 8'h75, 0, 0);
    idle(11, 0);
    chk("pre_rst_level", 32'(bus.level), 32'd2);
    cyc(0, 0, 8'h00, 0, 1);
    chk("rst_valid", 32'(bus.cmd_valid), 32'd0);
    idle(25, 1);

    // random traffic
    rst_seq();
    for (int i = 0; i < 3000; i++) begin
      logic v, mb, rdy, rs;
      logic [7:0] c;
      int k;
      v = ($urandom % 6) == 0;
      mb = $urandom % 2;
      k = $urandom % 5;
      c = (k < 4) ? 8'(codes[k]) : 8'h1C;
      rdy = ($urandom % 3) != 0;
      rs = ($urandom % 400) == 0;
      cyc(v, mb, c, rdy, rs);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end
endmodule
